// File: rtl/irq_ctrl.sv
// Interrupt controller: timer/sw/ext pending bits, fixed-priority select, single-level trap FSM.
// Build option IRQ_VECTORED_EN: irq_vector = base + 4*cause; otherwise irq_vector = base.
module irq_ctrl #(
    parameter  int unsigned XLEN    = 32,
    localparam int unsigned SRC_W   = 3,
    localparam int unsigned CAUSE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               timer_int,
    input  logic               ext_int,
    input  logic               sw_set,
    input  logic               mie_we,
    input  logic [SRC_W-1:0]   mie_wdata,
    input  logic               gie_we,
    input  logic               gie_wdata,
    input  logic [XLEN-1:0]    mtvec,
    input  logic [XLEN-1:0]    pc_in,
    input  logic               irq_ack,
    input  logic               mret,
    output logic               irq_req,
    output logic [CAUSE_W-1:0] irq_cause,
    output logic [XLEN-1:0]    irq_vector,
    output logic [XLEN-1:0]    epc,
    output logic [SRC_W-1:0]   pending,
    output logic               in_handler
);

    localparam logic [CAUSE_W-1:0] CAUSE_EXT   = CAUSE_W'(11);
    localparam logic [CAUSE_W-1:0] CAUSE_SW    = CAUSE_W'(3);
    localparam logic [CAUSE_W-1:0] CAUSE_TIMER = CAUSE_W'(7);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_HANDLER = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic               timer_q, timer_d;
    logic               ext_s1_q, ext_s1_d;
    logic               ext_s2_q, ext_s2_d;
    logic [SRC_W-1:0]   pending_q, pending_d;
    logic [SRC_W-1:0]   mask_q, mask_d;
    logic [SRC_W-1:0]   sel_q, sel_d;
    logic               gie_q, gie_d;
    logic               saved_gie_q, saved_gie_d;
    logic [XLEN-1:0]    epc_q, epc_d;
    logic [XLEN-1:0]    vector_q, vector_d;
    logic [CAUSE_W-1:0] cause_q, cause_d;
    logic               req_q, req_d;
    logic               hdl_q, hdl_d;

    logic [SRC_W-1:0]   set_c;
    logic [SRC_W-1:0]   clr_c;
    logic [SRC_W-1:0]   active_c;
    logic [XLEN-1:0]    vec_base_c;
    logic               unused_mtvec_lsb;

    assign vec_base_c       = {mtvec[XLEN-1:2], 2'b00};
    assign unused_mtvec_lsb = ^mtvec[1:0];

    // Next-state: edge detection, pending set/clear, CSR writes, trap FSM
    always_comb begin
        timer_d     = timer_int;
        ext_s1_d    = ext_int;
        ext_s2_d    = ext_s1_q;
        set_c       = {ext_s1_q & ~ext_s2_q, sw_set, timer_int & ~timer_q};
        active_c    = pending_q & mask_q;
        clr_c       = '0;
        state_d     = state_q;
        mask_d      = mie_we ? mie_wdata : mask_q;
        gie_d       = gie_we ? gie_wdata : gie_q;
        saved_gie_d = saved_gie_q;
        epc_d       = epc_q;
        sel_d       = sel_q;
        cause_d     = cause_q;
        vector_d    = vector_q;

        unique case (state_q)
            S_IDLE: begin
                if (gie_q && (active_c != '0)) begin
                    state_d = S_REQ;
                    if (active_c[2]) begin
                        sel_d   = 3'b100;
                        cause_d = CAUSE_EXT;
                    end else if (active_c[1]) begin
                        sel_d   = 3'b010;
                        cause_d = CAUSE_SW;
                    end else begin
                        sel_d   = 3'b001;
                        cause_d = CAUSE_TIMER;
                    end
`ifdef IRQ_VECTORED_EN
                    vector_d = vec_base_c + (XLEN'(cause_d) << 2);
`else
                    vector_d = vec_base_c;
`endif
                end
            end
            S_REQ: begin
                if (irq_ack) begin
                    state_d     = S_HANDLER;
                    epc_d       = pc_in;
                    clr_c       = sel_q;
                    saved_gie_d = gie_q;
                    gie_d       = 1'b0;
                end
            end
            S_HANDLER: begin
                if (mret) begin
                    state_d = S_IDLE;
                    gie_d   = saved_gie_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A coincident set beats the ack clear
        pending_d = (pending_q & ~clr_c) | set_c;
        req_d     = (state_d == S_REQ);
        hdl_d     = (state_d == S_HANDLER);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            timer_q     <= 1'b0;
            ext_s1_q    <= 1'b0;
            ext_s2_q    <= 1'b0;
            pending_q   <= '0;
            mask_q      <= '0;
            sel_q       <= '0;
            gie_q       <= 1'b0;
            saved_gie_q <= 1'b0;
            epc_q       <= '0;
            vector_q    <= '0;
            cause_q     <= '0;
            req_q       <= 1'b0;
            hdl_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            ext_s1_q    <= ext_s1_d;
            ext_s2_q    <= ext_s2_d;
            pending_q   <= pending_d;
            mask_q      <= mask_d;
            sel_q       <= sel_d;
            gie_q       <= gie_d;
            saved_gie_q <= saved_gie_d;
            epc_q       <= epc_d;
            vector_q    <= vector_d;
            cause_q     <= cause_d;
            req_q       <= req_d;
            hdl_q       <= hdl_d;
        end
    end

    assign irq_req    = req_q;
    assign irq_cause  = cause_q;
    assign irq_vector = vector_q;
    assign epc        = epc_q;
    assign pending    = pending_q;
    assign in_handler = hdl_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: per-cycle vector table plus hand-written priority and reset sequences.
module tb_irq_ctrl;

    logic        clk;
    logic        rst;
    logic        timer_int;
    logic        ext_int;
    logic        sw_set;
    logic        mie_we;
    logic [2:0]  mie_wdata;
    logic        gie_we;
    logic        gie_wdata;
    logic [31:0] mtvec;
    logic [31:0] pc_in;
    logic        irq_ack;
    logic        mret;
    logic        irq_req;
    logic [3:0]  irq_cause;
    logic [31:0] irq_vector;
    logic [31:0] epc;
    logic [2:0]  pending;
    logic        in_handler;

    int n_cmp = 0;
    int n_err = 0;

    irq_ctrl #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_int  (timer_int),
        .ext_int    (ext_int),
        .sw_set     (sw_set),
        .mie_we     (mie_we),
        .mie_wdata  (mie_wdata),
        .gie_we     (gie_we),
        .gie_wdata  (gie_wdata),
        .mtvec      (mtvec),
        .pc_in      (pc_in),
        .irq_ack    (irq_ack),
        .mret       (mret),
        .irq_req    (irq_req),
        .irq_cause  (irq_cause),
        .irq_vector (irq_vector),
        .epc        (epc),
        .pending    (pending),
        .in_handler (in_handler)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        timer;
        logic        sw;
        logic        ack;
        logic        mret;
        logic        mie_we;
        logic [2:0]  mie;
        logic        gie_we;
        logic        gie_w;
        logic [31:0] pc;
        logic        e_req;
        logic [3:0]  e_cause;
        logic [2:0]  e_pend;
        logic        e_hdl;
        logic [31:0] e_epc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic t, input logic s, input logic a, input logic m,
                                input logic mw, input logic [2:0] mv, input logic gw,
                                input logic gv, input logic [31:0] pc, input logic r,
                                input logic [3:0] c, input logic [2:0] p, input logic h,
                                input logic [31:0] e);
        vec_t v;
        v.timer = t;  v.sw = s;  v.ack = a;  v.mret = m;
        v.mie_we = mw; v.mie = mv; v.gie_we = gw; v.gie_w = gv; v.pc = pc;
        v.e_req = r;  v.e_cause = c; v.e_pend = p; v.e_hdl = h; v.e_epc = e;
        return v;
    endfunction

    // Handler address for mtvec = 0x100; zero before any request has been latched
    function automatic logic [31:0] exp_vec(input logic [3:0] c);
`ifdef IRQ_VECTORED_EN
        return (c == 4'd0) ? 32'h0 : 32'h100 + 32'(c) * 32'd4;
`else
        return (c == 4'd0) ? 32'h0 : 32'h100;
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic r, input logic [3:0] c,
                           input logic [2:0] p, input logic h, input logic [31:0] e);
        chk({nm, ".req"},    32'(irq_req),    32'(r));
        chk({nm, ".cause"},  32'(irq_cause),  32'(c));
        chk({nm, ".vector"}, irq_vector,      exp_vec(c));
        chk({nm, ".epc"},    epc,             e);
        chk({nm, ".pend"},   32'(pending),    32'(p));
        chk({nm, ".hdl"},    32'(in_handler), 32'(h));
    endtask

    task automatic idle_inputs();
        timer_int = 1'b0; sw_set = 1'b0; irq_ack = 1'b0; mret = 1'b0;
        mie_we = 1'b0; mie_wdata = 3'b000; gie_we = 1'b0; gie_wdata = 1'b0; pc_in = 32'h0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; ext_int = 1'b0; mtvec = 32'h103;
        idle_inputs();

        //            t  s  a  m  mw mie    gw gv pc        req cause pend   hdl epc
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b001, 1, 1, 32'h0,   0, 4'd0, 3'b000, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd0, 3'b001, 0, 32'h0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 32'h48,  0, 4'd7, 3'b000, 1, 32'h48));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 32'h99,  0, 4'd7, 3'b000, 1, 32'h48));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b000, 0, 32'h48));
        tbl.push_back(mk(1, 0, 0, 0, 1, 3'b001, 0, 0, 32'h0,   0, 4'd7, 3'b001, 0, 32'h48));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h48));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 32'h200, 0, 4'd7, 3'b000, 1, 32'h200));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 1, 0, 32'h0,   0, 4'd7, 3'b000, 0, 32'h200));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b000, 0, 32'h200));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b001, 0, 32'h200));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h200));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 32'h10,  0, 4'd7, 3'b000, 1, 32'h10));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b000, 0, 32'h10));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 1, 0, 32'h0,   0, 4'd7, 3'b000, 0, 32'h10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b001, 0, 32'h10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b001, 0, 32'h10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b001, 0, 32'h10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 1, 1, 32'h0,   0, 4'd7, 3'b001, 0, 32'h10));
        tbl.push_back(mk(1, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd7, 3'b001, 0, 32'h10));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 32'h300, 0, 4'd7, 3'b000, 1, 32'h300));
        tbl.push_back(mk(0, 1, 0, 0, 1, 3'b111, 0, 0, 32'h0,   0, 4'd7, 3'b010, 1, 32'h300));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b010, 1, 32'h300));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h0,   0, 4'd7, 3'b010, 0, 32'h300));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd3, 3'b010, 0, 32'h300));
        tbl.push_back(mk(0, 1, 1, 0, 0, 3'b000, 0, 0, 32'h44,  0, 4'd3, 3'b010, 1, 32'h44));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h0,   0, 4'd3, 3'b010, 0, 32'h44));
        tbl.push_back(mk(0, 0, 0, 0, 0, 3'b000, 0, 0, 32'h0,   1, 4'd3, 3'b010, 0, 32'h44));
        tbl.push_back(mk(0, 0, 1, 0, 0, 3'b000, 0, 0, 32'h50,  0, 4'd3, 3'b000, 1, 32'h50));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3'b000, 0, 0, 32'h0,   0, 4'd3, 3'b000, 0, 32'h50));

        step();
        step();
        chk_all("reset", 1'b0, 4'd0, 3'b000, 1'b0, 32'h0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            timer_int = tbl[i].timer;  sw_set = tbl[i].sw;  irq_ack = tbl[i].ack;
            mret = tbl[i].mret;  mie_we = tbl[i].mie_we;  mie_wdata = tbl[i].mie;
            gie_we = tbl[i].gie_we;  gie_wdata = tbl[i].gie_w;  pc_in = tbl[i].pc;
            step();
            chk_all($sformatf("v%0d", i), tbl[i].e_req, tbl[i].e_cause, tbl[i].e_pend,
                    tbl[i].e_hdl, tbl[i].e_epc);
        end
        idle_inputs();

        // ext rises one cycle ahead so both pending bits land on the same edge
        ext_int = 1'b1;
        step();
        chk_all("pri.sync", 1'b0, 4'd3, 3'b000, 1'b0, 32'h50);
        timer_int = 1'b1;
        step();
        chk_all("pri.pend", 1'b0, 4'd3, 3'b101, 1'b0, 32'h50);
        step();
        chk_all("pri.ext", 1'b1, 4'd11, 3'b101, 1'b0, 32'h50);
        irq_ack = 1'b1; pc_in = 32'h60;
        step();
        chk_all("pri.ack1", 1'b0, 4'd11, 3'b001, 1'b1, 32'h60);
        irq_ack = 1'b0; mret = 1'b1;
        step();
        chk_all("pri.mret1", 1'b0, 4'd11, 3'b001, 1'b0, 32'h60);
        mret = 1'b0;
        step();
        chk_all("pri.timer", 1'b1, 4'd7, 3'b001, 1'b0, 32'h60);
        irq_ack = 1'b1; pc_in = 32'h64;
        step();
        chk_all("pri.ack2", 1'b0, 4'd7, 3'b000, 1'b1, 32'h64);
        idle_inputs();
        ext_int = 1'b0;

        // Reset taken while in the handler, then recovery via a software interrupt
        step();
        chk_all("rst.pre", 1'b0, 4'd7, 3'b000, 1'b1, 32'h64);
        rst = 1'b0;
        #1;
        chk_all("rst.async", 1'b0, 4'd0, 3'b000, 1'b0, 32'h0);
        #1;
        rst = 1'b1;
        step();
        chk_all("rst.idle", 1'b0, 4'd0, 3'b000, 1'b0, 32'h0);
        mie_we = 1'b1; mie_wdata = 3'b010; gie_we = 1'b1; gie_wdata = 1'b1;
        step();
        idle_inputs();
        sw_set = 1'b1;
        step();
        chk_all("rst.swpend", 1'b0, 4'd0, 3'b010, 1'b0, 32'h0);
        sw_set = 1'b0;
        step();
        chk_all("rst.swreq", 1'b1, 4'd3, 3'b010, 1'b0, 32'h0);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
